// File: rtl/od_ttc_calc.sv
// od_ttc_calc: time-to-collision calculator.
// Clamps distance (cm), multiplies by SCALE and divides by speed (km/h) with a
// restoring divider, one quotient bit per cycle. The result is in 10 us units.
// Optional build macro: OD_TTC_ROUND_EN (round-half-up quotient instead of truncation).
module od_ttc_calc #(
   parameter int DIST_W      = 9,
   parameter int MAX_DIST_CM = 400,
   parameter int SCALE       = 3600,
   parameter int OUT_W       = 23
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIST_W-1:0] distance,
   input  logic [7:0]        speed,
   output logic              busy,
   output logic              valid,
   output logic [OUT_W-1:0]  time_taken,
   output logic              div_zero
);

   localparam int QW = 21;
   localparam logic [DIST_W-1:0] MAX_D = DIST_W'(MAX_DIST_CM);

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DIST_W-1:0] d_reg;
   logic [7:0]        s_reg;
   logic [QW-1:0]     dividend;
   logic [QW-1:0]     quot;
   logic [8:0]        rem;
   logic [4:0]        cnt;
   logic              sat;

   logic [QW-1:0]     d_ext;
   logic [QW-1:0]     prod;
   logic [9:0]        trial;
   logic              qbit;
   logic [8:0]        rem_nxt;
   logic [QW-1:0]     quot_nxt;

   assign d_ext = QW'(d_reg);

   // Dividend: d * SCALE (shift-add for the default 3600 = 2048+1024+512+16), plus optional rounding bias.
   always_comb begin
      prod = '0;
      if (SCALE == 3600)
         prod = (d_ext << 11) + (d_ext << 10) + (d_ext << 9) + (d_ext << 4);
      else
         prod = QW'(d_ext * SCALE);
`ifdef OD_TTC_ROUND_EN
      prod = prod + QW'(s_reg >> 1);
`else
      prod = prod;
`endif
   end

   // One restoring-division step: shift in the next dividend MSB and try to subtract the divisor.
   always_comb begin
      trial    = {rem, dividend[QW-1]};
      qbit     = (trial >= {2'b00, s_reg});
      rem_nxt  = qbit ? 9'(trial - {2'b00, s_reg}) : trial[8:0];
      quot_nxt = {quot[QW-2:0], qbit};
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic and status outputs.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      valid     = (state == DONE);
      case (state)
         IDLE:    if (start) state_nxt = MULT;
         MULT:    state_nxt = DIV;
         DIV:     if (cnt == 5'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: capture, multiply, divide and result registers.
   // The zero-speed path makes a single dummy DIV pass (counter 0) so its
   // valid lands two edges after the start edge, one edge after MULT.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_reg      <= '0;
         s_reg      <= '0;
         dividend   <= '0;
         quot       <= '0;
         rem        <= '0;
         cnt        <= '0;
         sat        <= 1'b0;
         time_taken <= '0;
         div_zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  d_reg <= (distance > MAX_D) ? MAX_D : distance;
                  s_reg <= speed;
               end
            end
            MULT: begin
               dividend <= prod;
               quot     <= '0;
               rem      <= '0;
               sat      <= (s_reg == 8'd0);
               cnt      <= (s_reg == 8'd0) ? 5'd0 : 5'd20;
            end
            DIV: begin
               dividend <= dividend << 1;
               rem      <= rem_nxt;
               quot     <= quot_nxt;
               cnt      <= cnt - 5'd1;
               if (cnt == 5'd0) begin
                  time_taken <= sat ? '1 : OUT_W'(quot_nxt);
                  div_zero   <= sat;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_od_ttc_calc.sv
// tb_od_ttc_calc: randomized and directed checks of od_ttc_calc against an
// arithmetic reference model (clamp, scale, divide, saturate on zero speed).
module tb_od_ttc_calc;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [8:0]  distance = '0;
   logic [7:0]  speed = '0;
   logic        busy;
   logic        valid;
   logic [22:0] time_taken;
   logic        div_zero;

   int checks = 0;
   int failures = 0;

   od_ttc_calc #(.DIST_W(9), .MAX_DIST_CM(400), .SCALE(3600), .OUT_W(23)) dut (
      .clk(clk), .rst(rst), .start(start), .distance(distance), .speed(speed),
      .busy(busy), .valid(valid), .time_taken(time_taken), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   // Reference: time = min(d,400)*3600 / s (optionally + s/2 before dividing); s==0 saturates.
   function automatic logic [22:0] model_tt(input int d, input int s);
      int dc;
      int num;
      if (s == 0) return 23'h7FFFFF;
      dc  = (d > 400) ? 400 : d;
      num = dc * 3600;
`ifdef OD_TTC_ROUND_EN
      num = num + s / 2;
`endif
      return 23'(num / s);
   endfunction

   // Launch one calculation and observe it; returns the first valid's data, its
   // latency in edges from the start edge, the valid count, and stability flags.
   task automatic do_run(input int d, input int s, output int lat, output logic [22:0] tt,
                         output logic dz, output int nvalid, output logic unstable,
                         output logic busy_drop);
      logic        got;
      logic [22:0] prev;
      @(negedge clk);
      distance = 9'(d);
      speed    = 8'(s);
      start    = 1'b1;
      prev     = time_taken;
      @(posedge clk); #1;
      start    = 1'b0;
      distance = 9'($urandom);
      speed    = 8'($urandom);
      lat = -1; tt = '0; dz = 1'b0; nvalid = 0; unstable = 1'b0; busy_drop = 1'b0; got = 1'b0;
      if (!busy) busy_drop = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (valid) begin
            nvalid++;
            if (!got) begin
               lat = i; tt = time_taken; dz = div_zero; got = 1'b1;
            end
         end else if (time_taken !== prev) begin
            unstable = 1'b1;
         end
         if (!got && !busy) busy_drop = 1'b1;
         prev = time_taken;
         if (got && !busy) break;
      end
   endtask

   task automatic test_reset();
      #3;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (time_taken !== 23'd0) begin failures++; $display("FAIL reset_time got=%0d exp=0", time_taken); end
      checks++; if (div_zero !== 1'b0) begin failures++; $display("FAIL reset_div_zero got=%b exp=0", div_zero); end
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Directed points plus a sanity check of latency and protocol for each.
   task automatic test_directed();
      int dv[6] = '{400, 100, 500, 2, 50, 1};
      int sv[6] = '{1, 36, 36, 7, 0, 8};
      int lat, nv;
      logic [22:0] tt;
      logic dz, uns, bd;
      for (int k = 0; k < 6; k++) begin
         do_run(dv[k], sv[k], lat, tt, dz, nv, uns, bd);
         checks++;
         if (tt !== model_tt(dv[k], sv[k])) begin
            failures++; $display("FAIL dir_time d=%0d s=%0d got=%0d exp=%0d", dv[k], sv[k], tt, model_tt(dv[k], sv[k]));
         end
         checks++;
         if (dz !== (sv[k] == 0)) begin
            failures++; $display("FAIL dir_div_zero d=%0d s=%0d got=%b exp=%b", dv[k], sv[k], dz, sv[k] == 0);
         end
         checks++;
         if (lat != ((sv[k] == 0) ? 2 : 22)) begin
            failures++; $display("FAIL dir_latency d=%0d s=%0d got=%0d exp=%0d", dv[k], sv[k], lat, (sv[k] == 0) ? 2 : 22);
         end
         checks++;
         if (nv != 1 || uns || bd) begin
            failures++; $display("FAIL dir_protocol d=%0d s=%0d nvalid=%0d unstable=%b busy_drop=%b exp=1/0/0", dv[k], sv[k], nv, uns, bd);
         end
      end
   endtask

   task automatic test_random();
      int lat, nv, d, s;
      logic [22:0] tt;
      logic dz, uns, bd;
      for (int k = 0; k < 40; k++) begin
         d = int'($urandom_range(511, 0));
         s = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(255, 1));
         do_run(d, s, lat, tt, dz, nv, uns, bd);
         checks++;
         if (tt !== model_tt(d, s) || dz !== (s == 0)) begin
            failures++; $display("FAIL rnd_result d=%0d s=%0d got=%0d/%b exp=%0d/%b", d, s, tt, dz, model_tt(d, s), s == 0);
         end
         checks++;
         if (lat != ((s == 0) ? 2 : 22) || nv != 1 || uns || bd) begin
            failures++; $display("FAIL rnd_timing d=%0d s=%0d lat=%0d nvalid=%0d unstable=%b busy_drop=%b", d, s, lat, nv, uns, bd);
         end
      end
   endtask

   // A second start five cycles into a run must be dropped, not queued.
   task automatic test_start_while_busy();
      int nv = 0;
      logic [22:0] tt = '0;
      logic busy_gap = 1'b0;
      logic got = 1'b0;
      @(negedge clk);
      distance = 9'd400; speed = 8'd240; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         if (i == 5) begin
            @(negedge clk);
            distance = 9'd10; speed = 8'd10; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
         if (valid) begin
            nv++;
            if (!got) begin tt = time_taken; got = 1'b1; end
         end
         if (!got && !busy) busy_gap = 1'b1;
      end
      checks++;
      if (nv != 1) begin failures++; $display("FAIL busy_valid_count got=%0d exp=1", nv); end
      checks++;
      if (tt !== model_tt(400, 240)) begin failures++; $display("FAIL busy_time got=%0d exp=%0d", tt, model_tt(400, 240)); end
      checks++;
      if (busy_gap !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL busy_hold gap=%b busy_end=%b exp=0/0", busy_gap, busy);
      end
   endtask

   // Asynchronous reset in the middle of a run aborts it.
   task automatic test_reset_mid();
      int nv = 0;
      int lat, nv2;
      logic [22:0] tt;
      logic dz, uns, bd;
      @(negedge clk);
      distance = 9'd123; speed = 8'd45; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0 || time_taken !== 23'd0) begin
         failures++; $display("FAIL mid_reset busy=%b valid=%b time=%0d exp=0/0/0", busy, valid, time_taken);
      end
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (valid) nv++;
      end
      checks++;
      if (nv != 0 || time_taken !== 23'd0) begin
         failures++; $display("FAIL mid_reset_after nvalid=%0d time=%0d exp=0/0", nv, time_taken);
      end
      do_run(77, 13, lat, tt, dz, nv2, uns, bd);
      checks++;
      if (tt !== model_tt(77, 13) || lat != 22 || nv2 != 1) begin
         failures++; $display("FAIL mid_reset_fresh time=%0d lat=%0d nvalid=%0d exp=%0d/22/1", tt, lat, nv2, model_tt(77, 13));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_while_busy();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Absolute time limit so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout reached=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule
